// File: rtl/tics_tick_divider.sv
// ---------------------------------------------------------------------------
// tics_tick_divider
//   Divides rising edges of an upstream tick level by a programmable reload
//   value. Periodic mode emits one terminal-count pulse every reload+1 edges
//   and reloads. One-shot mode emits a single pulse and parks in DONE until
//   the arm request is dropped.
//
// Ports
//   in_clk       sole clock, rising edge
//   in_reset     synchronous, active-high reset
//   in_tick      tick level from the upstream flop stage (acted on at rising edges)
//   in_load      strobe: write in_load_val into the reload register
//                (and into the count while counting)
//   in_load_val  reload value, WIDTH bits
//   in_arm       start request (level); dropping it returns to IDLE
//   in_mode      0 = periodic, 1 = one-shot, captured when leaving IDLE
//   out_count    current count register
//   out_tc       registered terminal-count pulse, one cycle wide
//   out_busy     high in COUNT
//   out_done     high in DONE
//
// State | meaning
//   IDLE  | waiting for in_arm; count holds its last value
//   COUNT | counting tick edges down to zero
//   DONE  | one-shot finished; waits for in_arm to drop
// ---------------------------------------------------------------------------
module tics_tick_divider #(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_tick,
  input  logic             in_load,
  input  logic [WIDTH-1:0] in_load_val,
  input  logic             in_arm,
  input  logic             in_mode,
  output logic [WIDTH-1:0] out_count,
  output logic             out_tc,
  output logic             out_busy,
  output logic             out_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nxt;
  logic             tc;
  logic             tc_nxt;
  logic             mode_q;
  logic             mode_nxt;
  logic             tick_prev;
  logic             tick_edge;

  // tick_prev resets high so a tick already high at reset release is not an edge.
  assign tick_edge = in_tick & ~tick_prev;

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      reload    <= '1;
      tc        <= 1'b0;
      mode_q    <= 1'b0;
      tick_prev <= 1'b1;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      reload    <= reload_nxt;
      tc        <= tc_nxt;
      mode_q    <= mode_nxt;
      tick_prev <= in_tick;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    tc_nxt     = 1'b0;
    mode_nxt   = mode_q;
    reload_nxt = in_load ? in_load_val : reload;

    case (state)
      ST_IDLE: begin
        if (in_arm) begin
          state_nxt = ST_COUNT;
          count_nxt = reload;
          mode_nxt  = in_mode;
        end
      end

      ST_COUNT: begin
        // Priority: load, terminal-count edge, disarm, decrement.
        if (in_load) begin
          count_nxt = in_load_val;
        end else if (tick_edge && (count == '0)) begin
          tc_nxt = 1'b1;
          if (mode_q) begin
            count_nxt = '0;
            state_nxt = ST_DONE;
          end else begin
            count_nxt = reload;
          end
        end else if (!in_arm) begin
          state_nxt = ST_IDLE;
        end else if (tick_edge) begin
          count_nxt = count - COUNT_ONE;
        end
      end

      ST_DONE: begin
        if (!in_arm) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_count = count;
  assign out_tc    = tc;
  assign out_busy  = (state == ST_COUNT);
  assign out_done  = (state == ST_DONE);

endmodule

// File: tb/tb_tics_tick_divider.sv
module tb_tics_tick_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick;
  logic         load;
  logic [W-1:0] load_val;
  logic         arm;
  logic         mode;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int tc_seen = 0;
  bit prev_tc_obs = 0;

  // Reference model: phase 0 = waiting, 1 = counting, 2 = finished one-shot.
  int m_phase;
  int m_count;
  int m_reload;
  int m_mode;
  int m_prev;
  int m_tc;

  always #5 clk = ~clk;

  tics_tick_divider #(.WIDTH(W)) dut (
    .in_clk      (clk),
    .in_reset    (reset),
    .in_tick     (tick),
    .in_load     (load),
    .in_load_val (load_val),
    .in_arm      (arm),
    .in_mode     (mode),
    .out_count   (count),
    .out_tc      (tc),
    .out_busy    (busy),
    .out_done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Applies the divider rules to the inputs sampled at one clock edge.
  task automatic model_step();
    int rising;
    int old_reload;
    if (reset) begin
      m_phase  = 0;
      m_count  = 0;
      m_reload = (1 << W) - 1;
      m_mode   = 0;
      m_prev   = 1;
      m_tc     = 0;
      return;
    end
    rising     = (tick && m_prev == 0) ? 1 : 0;
    old_reload = m_reload;
    m_tc       = 0;
    if (load) m_reload = int'(load_val);
    if (m_phase == 0) begin
      if (arm) begin
        m_phase = 1;
        m_count = old_reload;
        m_mode  = int'(mode);
      end
    end else if (m_phase == 1) begin
      if (load) begin
        m_count = int'(load_val);
      end else if (rising == 1 && m_count == 0) begin
        m_tc = 1;
        if (m_mode == 1) begin
          m_count = 0;
          m_phase = 2;
        end else begin
          m_count = old_reload;
        end
      end else if (!arm) begin
        m_phase = 0;
      end else if (rising == 1) begin
        m_count = m_count - 1;
      end
    end else begin
      if (!arm) m_phase = 0;
    end
    m_prev = int'(tick);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("count", 32'(count), 32'(m_count));
    check("tc",    32'(tc),    32'(m_tc));
    check("busy",  32'(busy),  (m_phase == 1) ? 32'd1 : 32'd0);
    check("done",  32'(done),  (m_phase == 2) ? 32'd1 : 32'd0);
    check("busy_done_excl", 32'(busy & done), 32'd0);
    check("tc_width", 32'(tc & prev_tc_obs), 32'd0);
    prev_tc_obs = tc;
    if (tc) tc_seen++;
  endtask

  task automatic pulse();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  initial begin
    int exp_seq [8] = '{2, 1, 0, 3, 2, 1, 0, 3};

    reset = 1'b1; tick = 1'b0; load = 1'b0; load_val = '0; arm = 1'b0; mode = 1'b0;
    m_phase = 0; m_count = 0; m_reload = 255; m_mode = 0; m_prev = 1; m_tc = 0;
    cycle();
    cycle();
    check("reset_count", 32'(count), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    reset = 1'b0;

    // Periodic divide by 4.
    load = 1'b1; load_val = 8'd3;
    cycle();
    load = 1'b0; mode = 1'b0; arm = 1'b1;
    cycle();
    check("arm_count", 32'(count), 32'd3);
    tc_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      cycle();
      check("periodic_seq", 32'(count), 32'(exp_seq[i]));
      check("periodic_tc", 32'(tc), (i == 3 || i == 7) ? 32'd1 : 32'd0);
      tick = 1'b0;
      cycle();
    end
    check("periodic_tc_total", 32'(tc_seen), 32'd2);
    arm = 1'b0;
    cycle();
    check("disarm_busy", 32'(busy), 32'd0);

    // One-shot with reload 2.
    load = 1'b1; load_val = 8'd2;
    cycle();
    load = 1'b0; mode = 1'b1; arm = 1'b1;
    cycle();
    tc_seen = 0;
    for (int i = 0; i < 3; i++) pulse();
    check("oneshot_tc", 32'(tc_seen), 32'd1);
    check("oneshot_done", 32'(done), 32'd1);
    check("oneshot_busy", 32'(busy), 32'd0);
    check("oneshot_count", 32'(count), 32'd0);
    pulse();
    pulse();
    check("oneshot_no_more_tc", 32'(tc_seen), 32'd1);
    arm = 1'b0;
    cycle();
    check("oneshot_idle", 32'(done | busy), 32'd0);

    // Divide by 1 with tick toggling every cycle.
    load = 1'b1; load_val = 8'd0;
    cycle();
    load = 1'b0; mode = 1'b0; arm = 1'b1;
    cycle();
    tc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick = ~tick;
      cycle();
    end
    cycle();
    check("div1_tc_total", 32'(tc_seen), 32'd5);

    // Load coincident with terminal-count edge.
    check("pre_load_count", 32'(count), 32'd0);
    load = 1'b1; load_val = 8'd5; tick = 1'b1;
    cycle();
    check("load_over_tc_tc", 32'(tc), 32'd0);
    check("load_over_tc_count", 32'(count), 32'd5);
    load = 1'b0; tick = 1'b0;
    cycle();

    // Reset while counting at count 1.
    for (int i = 0; i < 4; i++) pulse();
    check("pre_reset_count", 32'(count), 32'd1);
    reset = 1'b1;
    cycle();
    check("mid_reset_count", 32'(count), 32'd0);
    check("mid_reset_busy",  32'(busy),  32'd0);
    check("mid_reset_tc",    32'(tc),    32'd0);
    reset = 1'b0;
    cycle();
    check("reset_reload_ones", 32'(count), 32'd255);
    arm = 1'b0;
    cycle();

    // Tick held high through reset release is not an edge.
    tick = 1'b1; reset = 1'b1;
    cycle();
    reset = 1'b0; load = 1'b1; load_val = 8'd3;
    cycle();
    load = 1'b0; arm = 1'b1;
    cycle();
    cycle();
    cycle();
    check("held_tick_no_dec", 32'(count), 32'd3);
    tick = 1'b0;
    cycle();
    tick = 1'b1;
    cycle();
    check("held_tick_then_edge", 32'(count), 32'd2);
    tick = 1'b0;
    arm = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick     = 1'($urandom_range(0, 1));
      arm      = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom_range(0, 5));
      mode     = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tics_tick_divider.md
TICS_TICK_DIVIDER -- requirements
Module: tics_tick_divider

Interface
REQ-001 Parameter: WIDTH, default 8, width of the count and reload registers.
REQ-002 in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 in_reset  input  1  synchronous, active-high reset.
REQ-004 in_tick  input  1  level output of the upstream tics flop stage (its out_2 net), synchronous to in_clk; the block acts on its rising edges only.
REQ-005 in_load  input  1  load strobe for the reload register.
REQ-006 in_load_val  input  WIDTH  value written on in_load.
REQ-007 in_arm  input  1  start request (level).
REQ-008 in_mode  input  1  0 = periodic, 1 = one-shot; sampled on the IDLE->COUNT transition only.
REQ-009 out_count  output  WIDTH  current count register.
REQ-010 out_tc  output  1  terminal-count pulse, registered.
REQ-011 out_busy  output  1  high in COUNT.
REQ-012 out_done  output  1  high in DONE.

Function
REQ-013 Edge detect: tick_prev register; edge = in_tick & ~tick_prev, evaluated each cycle; tick_prev <= in_tick every cycle.
REQ-014 FSM states IDLE, COUNT, DONE; encoding free; no other reachable states.
REQ-015 IDLE: in_arm=1 -> COUNT, count <= reload, mode_q <= in_mode; otherwise stay, count unchanged.
REQ-016 COUNT, edge and count != 0: count <= count - 1, no tc.
REQ-017 COUNT, edge and count == 0: out_tc <= 1 for exactly one cycle; mode_q=0 -> count <= reload, stay in COUNT; mode_q=1 -> count <= 0, go to DONE.
REQ-018 COUNT, in_arm=0 with no edge at count 0: -> IDLE, count held, no tc.
REQ-019 DONE: out_done=1; in_arm=0 -> IDLE; in_arm=1 -> stay in DONE (re-arm requires in_arm low for at least one cycle).
REQ-020 in_load=1 in any state: reload <= in_load_val; additionally in COUNT, count <= in_load_val, overriding REQ-016/017 decrement/reload that cycle, with no tc that cycle.
REQ-021 Precedence within COUNT: in_load > terminal-count edge > in_arm=0 disarm > decrement.
REQ-022 Reload value 0: each tick edge in COUNT produces one out_tc (divide-by-1); value N gives one tc per N+1 edges.
REQ-023 Count arithmetic is unsigned WIDTH-bit; no wrap below 0 (REQ-017 intercepts zero).
REQ-024 Latency: out_tc asserts in the cycle after the clock edge at which in_tick is first sampled high following a low sample, with count == 0.
REQ-025 Back-to-back: in_tick toggling every cycle yields an edge every second cycle; no edge lost or doubled.
REQ-026 out_busy and out_done are decoded from the state register, glitch-free; never both high.

Reset
REQ-027 in_reset=1 at a clock edge: state <= IDLE, count <= 0, reload <= all ones, out_tc <= 0, mode_q <= 0, tick_prev <= 1.
REQ-028 tick_prev resets to 1 so that in_tick already high at reset release is not an edge.
REQ-029 in_reset overrides all other inputs, including mid-COUNT and while out_tc is high (out_tc low the cycle after).

Verification
REQ-030 Reset, load 3, mode 0, arm, 8 clean tick pulses -> out_tc on the 4th and 8th edges, out_count sequence 3,2,1,0,3,2,1,0,3.
REQ-031 Load 2, mode 1, arm, 3 edges -> single out_tc, then out_done=1, out_busy=0, out_count=0; further edges give no tc; in_arm low -> IDLE.
REQ-032 Load 0, mode 0, arm, in_tick toggling every cycle for 10 cycles -> 5 out_tc pulses, each one cycle wide.
REQ-033 COUNT at count 0, in_load=1 with value 5 coincident with tick edge -> no tc, out_count=5 next cycle.
REQ-034 Hold in_tick=1 through reset release, arm -> no decrement until in_tick goes low then high.
REQ-035 Assert in_reset mid-COUNT (count=1) -> next cycle IDLE, out_count=0, out_busy=0, out_tc=0, reload=all ones.
